// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-unit state encoding, next-PC source select and
// the default reset vector.
package cpu_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JR     = 2'd3
    } pc_sel_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Priority encoder for the next-PC source: jr > jump > branch > seq.
    function automatic pc_sel_t pick_sel(input logic jr, input logic jump,
                                         input logic branch);
        if (jr)
            return SEL_JR;
        else if (jump)
            return SEL_JUMP;
        else if (branch)
            return SEL_BRANCH;
        else
            return SEL_SEQ;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target computation and selection.
// Every candidate is computed modulo 2^W, so PC wrap-around falls out naturally.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_pc_plus4,
    input  logic         i_branch,
    input  logic         i_jump,
    input  logic         i_jr,
    input  logic [15:0]  i_imm16,
    input  logic [25:0]  i_jidx,
    input  logic [W-1:0] i_rs_val,
    output logic [W-1:0] o_next_pc,
    output logic         o_jr_misalign
);

    // Bits of the PC replaced by a J-type target; the top bits come from pc+4.
    localparam logic [W-1:0] LOW_MASK = W'({28{1'b1}});

    logic signed [17:0] w_offset;
    logic [W-1:0]       w_btgt;
    logic [W-1:0]       w_jtgt;
    pc_sel_t            w_sel;

    assign w_offset      = {i_imm16, 2'b00};
    assign w_btgt        = i_pc_plus4 + W'(w_offset);
    assign w_jtgt        = (i_pc_plus4 & ~LOW_MASK) | (W'({i_jidx, 2'b00}) & LOW_MASK);
    assign w_sel         = pick_sel(i_jr, i_jump, i_branch);
    assign o_jr_misalign = i_jr && (i_rs_val[1:0] != 2'b00);

    always_comb begin
        o_next_pc = i_pc_plus4;
        case (w_sel)
            SEL_JR:     o_next_pc = i_rs_val;
            SEL_JUMP:   o_next_pc = w_jtgt;
            SEL_BRANCH: o_next_pc = w_btgt;
            default:    o_next_pc = i_pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, saturating instruction counter and the
// RUN/HALT state machine. Target arithmetic lives in next_pc_calc.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         halt,
    input  logic         branch,
    input  logic         jump,
    input  logic         jr,
    input  logic [15:0]  imm16,
    input  logic [25:0]  jidx,
    input  logic [W-1:0] rs_val,
    output logic [W-1:0] pc,
    output logic [W-1:0] pc_plus4,
    output logic         running,
    output logic         misalign,
    output logic [W-1:0] inst_count,
    output pc_state_t    state
);

    pc_state_t    r_state;
    logic [W-1:0] r_pc;
    logic [W-1:0] r_inst_count;
    logic         r_misalign;
    logic [W-1:0] w_pc_plus4;
    logic [W-1:0] w_next_pc;
    logic         w_jr_bad;

    assign w_pc_plus4 = r_pc + W'(4);

    next_pc_calc #(
        .W (W)
    ) u_calc (
        .i_pc_plus4    (w_pc_plus4),
        .i_branch      (branch),
        .i_jump        (jump),
        .i_jr          (jr),
        .i_imm16       (imm16),
        .i_jidx        (jidx),
        .i_rs_val      (rs_val),
        .o_next_pc     (w_next_pc),
        .o_jr_misalign (w_jr_bad)
    );

    // Halt outranks stall, and stall masks every control-flow select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_inst_count <= '0;
            r_misalign   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt) begin
                        r_state <= ST_HALT;
                    end else if (stall) begin
                        r_state <= ST_RUN;
                    end else if (w_jr_bad) begin
                        r_misalign <= 1'b1;
                        r_state    <= ST_HALT;
                    end else begin
                        r_pc <= w_next_pc;
                        if (r_inst_count != '1)
                            r_inst_count <= r_inst_count + W'(1);
                    end
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign running    = (r_state == ST_RUN);
    assign misalign   = r_misalign;
    assign inst_count = r_inst_count;
    assign state      = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for control flow and a 4-bit
// instance for wrap-around and counter saturation.
module tb_pc_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        rst, stall, halt, branch, jump, jr;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] rs_val;
    logic [31:0] pc, pc_plus4, inst_count;
    logic        running, misalign;
    pc_state_t   state;

    logic        rst_s;
    logic [3:0]  pc_s, pc_plus4_s, inst_count_s;
    logic        running_s, misalign_s;
    pc_state_t   state_s;

    logic [31:0] exp_q[$];
    logic [31:0] cnt_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    pc_unit #(.W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .branch(branch),
        .jump(jump), .jr(jr), .imm16(imm16), .jidx(jidx), .rs_val(rs_val),
        .pc(pc), .pc_plus4(pc_plus4), .running(running), .misalign(misalign),
        .inst_count(inst_count), .state(state)
    );

    pc_unit #(.W(4), .RESET_PC(4'hC)) dut_s (
        .clk(clk), .rst(rst_s), .stall(1'b0), .halt(1'b0), .branch(1'b0),
        .jump(1'b0), .jr(1'b0), .imm16(16'h0), .jidx(26'h0), .rs_val(4'h0),
        .pc(pc_s), .pc_plus4(pc_plus4_s), .running(running_s), .misalign(misalign_s),
        .inst_count(inst_count_s), .state(state_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run did not reach its end (observed running, expected finished)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic hl, input logic br, input logic jp,
                         input logic j_r, input logic [15:0] im, input logic [25:0] ji,
                         input logic [31:0] rs);
        stall = st; halt = hl; branch = br; jump = jp; jr = j_r;
        imm16 = im; jidx = ji; rs_val = rs;
    endtask

    // Push the expected pc/count for the inputs just driven, clock, then compare.
    task automatic step(input string tag, input logic [31:0] e_pc, input logic [31:0] e_cnt);
        exp_q.push_back(e_pc);
        cnt_q.push_back(e_cnt);
        tick();
        chk({tag, ".pc"}, pc, exp_q.pop_front());
        chk({tag, ".cnt"}, inst_count, cnt_q.pop_front());
    endtask

    initial begin
        rst = 1'b0; rst_s = 1'b0;
        drive(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        #1 rst = 1'b1; rst_s = 1'b1;
        #1;
        chk("reset.pc", pc, 32'h0);
        chk("reset.pc_plus4", pc_plus4, 32'h4);
        chk("reset.running", 32'(running), 32'h1);
        chk("reset.misalign", 32'(misalign), 32'h0);
        chk("reset.cnt", inst_count, 32'h0);
        chk("reset.state", 32'(state), 32'(ST_RUN));
        #1 rst = 1'b0;

        step("idle1", 32'h4, 32'd1);
        step("idle2", 32'h8, 32'd2);
        step("idle3", 32'hC, 32'd3);
        chk("idle3.pc_plus4", pc_plus4, 32'h10);

        drive(0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h100);
        step("jr_0x100", 32'h100, 32'd4);
        drive(0, 0, 1, 0, 0, 16'hFFFF, 26'h0, 32'h0);
        step("br_neg1", 32'h100, 32'd5);
        drive(0, 0, 1, 0, 0, 16'h0004, 26'h0, 32'h0);
        step("br_pos4", 32'h114, 32'd6);

        drive(0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h3000_0000);
        step("jr_0x3000", 32'h3000_0000, 32'd7);
        drive(0, 0, 1, 1, 0, 16'h0004, 26'h40, 32'h0);
        step("jump_over_br", 32'h3000_0100, 32'd8);
        drive(0, 0, 1, 1, 1, 16'h0004, 26'h1, 32'h2000);
        step("jr_over_jump", 32'h2000, 32'd9);

        drive(1, 0, 1, 0, 0, 16'h0004, 26'h0, 32'h0);
        step("stall1", 32'h2000, 32'd9);
        step("stall2", 32'h2000, 32'd9);
        chk("stall.running", 32'(running), 32'h1);

        drive(0, 0, 0, 0, 1, 16'h0, 26'h0, 32'hFFFF_FFFC);
        step("jr_top", 32'hFFFF_FFFC, 32'd10);
        chk("top.pc_plus4", pc_plus4, 32'h0);
        drive(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        step("seq_wrap", 32'h0, 32'd11);
        step("seq_after_wrap", 32'h4, 32'd12);

        drive(0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h202);
        step("jr_misaligned", 32'h4, 32'd12);
        chk("jr_bad.misalign", 32'(misalign), 32'h1);
        chk("jr_bad.running", 32'(running), 32'h0);
        chk("jr_bad.state", 32'(state), 32'(ST_HALT));
        drive(0, 0, 1, 1, 1, 16'h0004, 26'h5, 32'h400);
        step("halt_ignore1", 32'h4, 32'd12);
        drive(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        step("halt_ignore2", 32'h4, 32'd12);
        chk("halt.pc_plus4", pc_plus4, 32'h8);
        chk("halt.misalign", 32'(misalign), 32'h1);

        // Reset lands between edges with a branch pending.
        drive(0, 0, 1, 0, 0, 16'h0004, 26'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("midrst.pc", pc, 32'h0);
        chk("midrst.cnt", inst_count, 32'h0);
        chk("midrst.misalign", 32'(misalign), 32'h0);
        chk("midrst.running", 32'(running), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_branch", 32'h14, 32'd1);

        drive(1, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        step("stall_halt", 32'h14, 32'd1);
        chk("stall_halt.state", 32'(state), 32'(ST_HALT));
        chk("stall_halt.running", 32'(running), 32'h0);
        chk("stall_halt.misalign", 32'(misalign), 32'h0);
        drive(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
        step("halt_hold", 32'h14, 32'd1);

        // Narrow instance: 4-bit PC wrap and counter saturation at 4'hF.
        chk("small.reset_pc", 32'(pc_s), 32'hC);
        chk("small.reset_cnt", 32'(inst_count_s), 32'h0);
        @(negedge clk);
        rst_s = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk($sformatf("small.pc%0d", n), 32'(pc_s), (32'hC + 32'(4 * n)) & 32'hF);
            chk($sformatf("small.cnt%0d", n), 32'(inst_count_s), (n > 15) ? 32'd15 : 32'(n));
        end
        chk("small.running", 32'(running_s), 32'h1);
        chk("small.misalign", 32'(misalign_s), 32'h0);
        chk("small.pc_plus4", 32'(pc_plus4_s), 32'((pc_s + 4'h4) & 4'hF));
        chk("small.state", 32'(state_s), 32'(ST_RUN));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter W, default 32, SHALL be the PC and counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 stall  input  1  SHALL hold the PC for the current cycle.
REQ-006 halt  input  1  SHALL request entry to the HALT state.
REQ-007 branch  input  1  SHALL be the combined branch-taken select from the upstream branch-OR stage.
REQ-008 jump  input  1  SHALL select the J-type target.
REQ-009 jr  input  1  SHALL select the register target.
REQ-010 imm16  input  16  SHALL be the branch offset in instruction words.
REQ-011 jidx  input  26  SHALL be the J-type word index.
REQ-012 rs_val  input  W  SHALL be the register jump target.
REQ-013 pc  output  W  SHALL be the current PC, registered.
REQ-014 pc_plus4  output  W  SHALL be pc+4, combinational.
REQ-015 running  output  1  SHALL be high in the RUN state.
REQ-016 misalign  output  1  SHALL be a sticky flag for a rejected jr target.
REQ-017 inst_count  output  W  SHALL count executed instructions.

Function
REQ-018 Next-PC candidates SHALL be: seq = pc+4; btgt = pc+4 + (sign-extended imm16 << 2); jtgt = {pc_plus4[31:28], jidx, 2'b00}; rtgt = rs_val.
REQ-019 Selection priority SHALL be jr > jump > branch > seq; all arithmetic SHALL be modulo 2^W, with wrap-around allowed (pc=32'hFFFF_FFFC, seq -> 32'h0000_0000).
REQ-020 The state machine SHALL have two states, RUN and HALT; reset SHALL enter RUN.
REQ-021 In RUN with stall=0 and halt=0, pc SHALL load the selected next-PC at the edge, giving one-cycle latency.
REQ-022 In RUN with stall=1, pc and inst_count SHALL hold; branch, jump and jr SHALL be ignored that cycle.
REQ-023 In RUN with halt=1, the block SHALL enter HALT at the edge, with pc held; halt SHALL take priority over stall.
REQ-024 If jr=1, stall=0 and rs_val[1:0]!=0, pc SHALL hold, misalign SHALL set, and the state SHALL go to HALT.
REQ-025 HALT SHALL be absorbing: pc and inst_count hold and all inputs are ignored until rst.
REQ-026 inst_count SHALL increment by 1 for each RUN cycle that loads pc, and SHALL saturate at all-ones.
REQ-027 pc_plus4 SHALL always equal pc+4 in every state.

Reset
REQ-028 On rst, the outputs SHALL go immediately to: pc=RESET_PC, state=RUN, running=1, misalign=0, inst_count=0.
REQ-029 A reset asserted mid-operation SHALL discard any pending selection, and the first load after deassertion SHALL use RESET_PC as the base.

Structure
REQ-030 The state encoding (RUN=1'b0, HALT=1'b1) and the default RESET_PC SHALL live in the shared package cpu_pkg.
REQ-031 Target computation SHALL be a combinational sub-module, next_pc_calc; pc_unit SHALL keep only the registers and the FSM.

Verification
REQ-032 Reset then 3 idle cycles -> pc 0x0, 0x4, 0x8, 0xC; inst_count=3.
REQ-033 pc=0x100, branch=1, imm16=16'hFFFF -> next pc=0x100; imm16=0x0004 -> next pc=0x114.
REQ-034 pc=0x3000_0000, jump=1, branch=1, jidx=26'h40 -> pc=0x3000_0100 (jump wins).
REQ-035 jr=1, rs_val=0x202 -> pc holds, misalign=1, running=0; later stimulus has no effect until rst.
REQ-036 stall=1 for 2 cycles with branch=1 -> pc and inst_count unchanged; stall and halt together -> HALT.
REQ-037 pc=0xFFFF_FFFC, seq -> pc=0x0; with inst_count preset near all-ones, 2 loads -> count saturates at all-ones; rst asserted mid-cycle -> pc=RESET_PC immediately.
